if_fetch_unit: RTL and testbench

Instruction-fetch front end of the five-stage pipeline. Owns the program counter, issues word reads to instruction memory over a single-outstanding req/rvalid handshake, and presents each fetched instruction with its PC+4 to the IF/ID pipeline register. Honours the hazard unit's `freeze` and the EXE stage's branch redirect. Delivers a zero instruction (pipeline bubble) whenever no valid fetch is available.

---
 rtl/if_fetch_unit.sv | 117 +++++++++++
 tb/tb_if_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, single-outstanding imem req/rvalid handshake.
// Optional freeze buffer enabled by defining IF_FETCH_BUF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        inst_valid
);

`ifdef IF_FETCH_BUF_EN
  typedef enum logic [1:0] {IDLE, REQ, KILL, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic        w_take;

`ifdef IF_FETCH_BUF_EN
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc4;
`endif

  assign w_pc4  = r_pc + 32'd4;
  assign w_take = (r_state == REQ) && imem_rvalid && !branch_taken && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
`ifdef IF_FETCH_BUF_EN
      r_buf_inst <= '0;
      r_buf_pc4  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (branch_taken) r_pc <= branch_addr;
          r_state <= REQ;
        end
        REQ: begin
          if (branch_taken) begin
            r_pc    <= branch_addr;
            r_state <= imem_rvalid ? IDLE : KILL;
          end else if (imem_rvalid) begin
            if (!freeze) begin
              r_pc    <= w_pc4;
              r_state <= IDLE;
            end else begin
`ifdef IF_FETCH_BUF_EN
              r_buf_inst <= imem_rdata;
              r_buf_pc4  <= w_pc4;
              r_state    <= HOLD;
`else
              // Drop the word; pc is kept so the same address is re-fetched.
              r_state <= IDLE;
`endif
            end
          end
        end
        KILL: begin
          // A late redirect retargets pc but the killed response still ends KILL,
          // otherwise the FSM would wait for a response that never comes.
          if (branch_taken) r_pc <= branch_addr;
          if (imem_rvalid) r_state <= IDLE;
        end
`ifdef IF_FETCH_BUF_EN
        HOLD: begin
          if (branch_taken) begin
            r_buf_inst <= '0;
            r_buf_pc4  <= '0;
            r_pc       <= branch_addr;
            r_state    <= IDLE;
          end else if (!freeze) begin
            r_pc    <= w_pc4;
            r_state <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req    = (r_state == REQ);
    imem_addr   = imem_req ? r_pc : '0;
    inst_valid  = 1'b0;
    PC          = '0;
    Instruction = '0;
    if (w_take) begin
      inst_valid  = 1'b1;
      PC          = w_pc4;
      Instruction = imem_rdata;
    end
`ifdef IF_FETCH_BUF_EN
    if (r_state == HOLD) begin
      inst_valid  = 1'b1;
      PC          = r_buf_pc4;
      Instruction = r_buf_inst;
    end
`endif
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for fetch/redirect, hand sequences for
// freeze, reset mid-request and PC wrap-around (second instance with RESET_PC=FFFF_FFFC).
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_a, rst_b;
  logic        freeze, branch_taken, imem_rvalid;
  logic [31:0] branch_addr, imem_rdata;

  logic        req_a, vld_a, req_b, vld_b;
  logic [31:0] addr_a, pc_a, inst_a, addr_b, pc_b, inst_b;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(req_a), .imem_addr(addr_a),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .PC(pc_a),
    .Instruction(inst_a), .inst_valid(vld_a)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .PC(pc_b),
    .Instruction(inst_b), .inst_valid(vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, frz, br;
    logic [31:0] baddr;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl[35];

  task automatic chk(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h want %h", name, fld, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, compare outputs 1ns later (before the posedge).
  task automatic cyc(input int unsigned sel, input logic r, input logic f, input logic b,
                     input logic [31:0] ba, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei, input string name);
    @(negedge clk);
    rst_a = (sel == 0) ? r : 1'b1;
    rst_b = (sel == 0) ? 1'b1 : r;
    freeze = f; branch_taken = b; branch_addr = ba; imem_rvalid = rv; imem_rdata = rd;
    #1;
    if (sel == 0) begin
      chk(name, "req", {31'b0, req_a}, {31'b0, er});
      chk(name, "addr", addr_a, ea);
      chk(name, "valid", {31'b0, vld_a}, {31'b0, ev});
      chk(name, "pc", pc_a, ep);
      chk(name, "inst", inst_a, ei);
    end else begin
      chk(name, "req", {31'b0, req_b}, {31'b0, er});
      chk(name, "addr", addr_b, ea);
      chk(name, "valid", {31'b0, vld_b}, {31'b0, ev});
      chk(name, "pc", pc_b, ep);
      chk(name, "inst", inst_b, ei);
    end
  endtask

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    //            name          rst   frz   br    baddr        rv    rdata          req   addr         vld   pc           inst
    tbl[0]  = '{"rst_hold",   1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[1]  = '{"rst_rel",    1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[2]  = '{"req0",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[3]  = '{"dlv0",       1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hA000_0000, 1'b1, 32'h0,       1'b1, 32'h4,       32'hA000_0000};
    tbl[4]  = '{"gap0",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[5]  = '{"req4",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h4,       1'b0, 32'h0,       32'h0};
    tbl[6]  = '{"dlv1",       1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hA111_1111, 1'b1, 32'h4,       1'b1, 32'h8,       32'hA111_1111};
    tbl[7]  = '{"gap1",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[8]  = '{"req8",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h8,       1'b0, 32'h0,       32'h0};
    tbl[9]  = '{"dlv2",       1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hA222_2222, 1'b1, 32'h8,       1'b1, 32'hC,       32'hA222_2222};
    tbl[10] = '{"gap2",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[11] = '{"br_infl",    1'b0, 1'b0, 1'b1, 32'h100,     1'b0, 32'h0,         1'b1, 32'hC,       1'b0, 32'h0,       32'h0};
    tbl[12] = '{"kill_wait",  1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[13] = '{"kill_drop",  1'b0, 1'b0, 1'b0, 32'h0,       1'b1, JUNK,          1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[14] = '{"idle_k",     1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[15] = '{"req100a",    1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h100,     1'b0, 32'h0,       32'h0};
    tbl[16] = '{"req100b",    1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h100,     1'b0, 32'h0,       32'h0};
    tbl[17] = '{"dlv100",     1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hB000_0000, 1'b1, 32'h100,     1'b1, 32'h104,     32'hB000_0000};
    tbl[18] = '{"gap3",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[19] = '{"req104",     1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h104,     1'b0, 32'h0,       32'h0};
    tbl[20] = '{"br_rv",      1'b0, 1'b0, 1'b1, 32'h200,     1'b1, 32'hC000_0000, 1'b1, 32'h104,     1'b0, 32'h0,       32'h0};
    tbl[21] = '{"idle_brrv",  1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[22] = '{"req200",     1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h200,     1'b0, 32'h0,       32'h0};
    tbl[23] = '{"dlv200",     1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC111_1111, 1'b1, 32'h200,     1'b1, 32'h204,     32'hC111_1111};
    tbl[24] = '{"idle_br",    1'b0, 1'b0, 1'b1, 32'h300,     1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[25] = '{"req300",     1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h300,     1'b0, 32'h0,       32'h0};
    tbl[26] = '{"dlv300",     1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hD000_0000, 1'b1, 32'h300,     1'b1, 32'h304,     32'hD000_0000};
    tbl[27] = '{"gap4",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[28] = '{"br_kill1",   1'b0, 1'b0, 1'b1, 32'h400,     1'b0, 32'h0,         1'b1, 32'h304,     1'b0, 32'h0,       32'h0};
    tbl[29] = '{"br_kill2",   1'b0, 1'b0, 1'b1, 32'h500,     1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[30] = '{"kill_drop2", 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, JUNK,          1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[31] = '{"gap5",       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,       32'h0};
    tbl[32] = '{"req500",     1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 32'h500,     1'b0, 32'h0,       32'h0};
    tbl[33] = '{"dlv500",     1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hE000_0000, 1'b1, 32'h500,     1'b1, 32'h504,     32'hE000_0000};
    tbl[34] = '{"stray_idle", 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, JUNK,          1'b0, 32'h0,       1'b0, 32'h0,       32'h0};

    rst_a = 1'b1; rst_b = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    branch_addr = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 35; i++)
      cyc(0, tbl[i].rst, tbl[i].frz, tbl[i].br, tbl[i].baddr, tbl[i].rv, tbl[i].rdata,
          tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_inst, tbl[i].name);

    // Freeze held three cycles over the response at 0x20.
    cyc(0, 0, 0, 1, 32'h20, 0, 0,    1, 32'h504, 0, 0, 0, "br_to20");
    cyc(0, 0, 0, 0, 0,      1, JUNK, 0, 0,       0, 0, 0, "kill20");
    cyc(0, 0, 1, 0, 0,      0, 0,    0, 0,       0, 0, 0, "idle_frz");
    cyc(0, 0, 0, 0, 0,      0, 0,    1, 32'h20,  0, 0, 0, "req20");
    cyc(0, 0, 1, 0, 0,      1, 32'hF000_0000, 1, 32'h20, 0, 0, 0, "frz_rsp");
`ifdef IF_FETCH_BUF_EN
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h24, 32'hF000_0000, "hold1");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h24, 32'hF000_0000, "hold2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h24, 32'hF000_0000, "hold_rel");
`else
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, "frz_idle");
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, "rereq20_frz");
    cyc(0, 0, 0, 0, 0, 1, 32'hF000_0000, 1, 32'h20, 1, 32'h24, 32'hF000_0000, "rereq20_dlv");
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, "idle_after_frz");

    // Reset while a request is outstanding, then a stray response.
    cyc(0, 1, 0, 0, 0, 0, 0,    1, 32'h24, 0, 0, 0, "rst_mid");
    cyc(0, 1, 0, 0, 0, 1, JUNK, 0, 0,      0, 0, 0, "rst_stray");
    cyc(0, 0, 0, 0, 0, 1, JUNK, 0, 0,      0, 0, 0, "stray_after");
    cyc(0, 0, 0, 0, 0, 0, 0,    1, 32'h0,  0, 0, 0, "rereq_reset_pc");

    // PC wrap on the RESET_PC=FFFF_FFFC instance.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, "wrap_rst");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, "wrap_idle");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, "wrap_req");
    cyc(1, 0, 0, 0, 0, 1, 32'h9999_0000, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h9999_0000, "wrap_dlv");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, "wrap_gap");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, "wrap_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
